// File: rtl/fetch_buffer.sv
// Fetch buffer: accepts two-slot fetch packets, queues per-instruction entries,
// and presents the oldest entry to the decoder.
module fetch_buffer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [31:0]                if_pc,
  input  logic [31:0]                if_inst0,
  input  logic [31:0]                if_inst1,
  input  logic [1:0]                 if_mask,
  input  logic                       if_excp,
  input  logic [5:0]                 if_ecode,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [31:0]                id_pc,
  output logic [31:0]                id_inst,
  output logic                       id_excp,
  output logic [5:0]                 id_ecode,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] NOP_INST = 32'h0340_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
    logic [5:0]  ecode;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_rptr;
  logic [AW-1:0]   r_wptr;
  logic [CW-1:0]   r_count;

  entry_t          w_e0;
  entry_t          w_e1;
  logic [1:0]      w_n;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_free;
  logic [31:0]     w_pc4;
  entry_t          w_head;

  // Back-pressure from registered occupancy only: room for a full packet.
  always_comb begin
    w_free   = CW'(DEPTH) - r_count;
    if_ready = (w_free >= CW'(2));
    w_push   = if_valid && if_ready && !flush;
    w_pop    = id_valid && id_ready && !flush;
  end

  // Turn the incoming packet into up to two ordered entries.
  always_comb begin
    w_e0  = '0;
    w_e1  = '0;
    w_n   = 2'd0;
    w_pc4 = if_pc + 32'd4;
    if (if_excp) begin
      // One exception entry tagged with the first valid slot's PC.
      w_e0.pc    = (!if_mask[0] && if_mask[1]) ? w_pc4 : if_pc;
      w_e0.inst  = NOP_INST;
      w_e0.excp  = 1'b1;
      w_e0.ecode = if_ecode;
      w_n        = 2'd1;
    end else begin
      unique case (if_mask)
        2'b01: begin
          w_e0.pc   = if_pc;
          w_e0.inst = if_inst0;
          w_n       = 2'd1;
        end
        2'b10: begin
          w_e0.pc   = w_pc4;
          w_e0.inst = if_inst1;
          w_n       = 2'd1;
        end
        2'b11: begin
          w_e0.pc   = if_pc;
          w_e0.inst = if_inst0;
          w_e1.pc   = w_pc4;
          w_e1.inst = if_inst1;
          w_n       = 2'd2;
        end
        default: w_n = 2'd0;
      endcase
    end
  end

  // Storage writes; if_ready guarantees both target slots are free.
  always_ff @(posedge clk) begin
    if (rstn && w_push) begin
      if (w_n != 2'd0) r_mem[r_wptr] <= w_e0;
      if (w_n == 2'd2) r_mem[r_wptr + AW'(1)] <= w_e1;
    end
  end

  // Pointers and occupancy; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(w_n);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (w_push ? CW'(w_n) : CW'(0)) - CW'(w_pop);
    end
  end

  // Head presented straight from storage, zeroed when empty.
  always_comb begin
    id_valid = (r_count != '0);
    w_head   = r_mem[r_rptr];
    id_pc    = id_valid ? w_head.pc    : 32'd0;
    id_inst  = id_valid ? w_head.inst  : 32'd0;
    id_excp  = id_valid ? w_head.excp  : 1'b0;
    id_ecode = id_valid ? w_head.ecode : 6'd0;
    count    = r_count;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning queue entries; power of two, at least 4.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rstn, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port flush, input, 1, discard all queued and in-flight instructions.
REQ-005 SHALL have port if_valid, input, 1, fetch packet present.
REQ-006 SHALL have port if_ready, output, 1, buffer can accept a packet.
REQ-007 SHALL have port if_pc, input, 32, PC of slot 0; slot 1 PC = if_pc+4.
REQ-008 SHALL have port if_inst0, input, 32, slot 0 instruction word.
REQ-009 SHALL have port if_inst1, input, 32, slot 1 instruction word.
REQ-010 SHALL have port if_mask, input, 2, per-slot valid; bit0 = slot 0, bit1 = slot 1.
REQ-011 SHALL have port if_excp, input, 1, fetch exception for this packet.
REQ-012 SHALL have port if_ecode, input, 6, exception code.
REQ-013 SHALL have port id_valid, output, 1, head entry valid to decoder.
REQ-014 SHALL have port id_ready, input, 1, decoder accepts head.
REQ-015 SHALL have port id_pc, output, 32, head PC.
REQ-016 SHALL have port id_inst, output, 32, head instruction word.
REQ-017 SHALL have port id_excp, output, 1, head carries fetch exception.
REQ-018 SHALL have port id_ecode, output, 6, head exception code.
REQ-019 SHALL have port count, output, $clog2(DEPTH)+1, occupied entries.

Function
REQ-020 SHALL push when if_valid && if_ready && !flush; SHALL pop when id_valid && id_ready && !flush.
REQ-021 SHALL drive if_ready = (DEPTH - count) >= 2, from registered count only; no combinational path from id_ready.
REQ-022 Push SHALL write valid slots in order (slot 0 then slot 1), skipping masked slots; mask 2'b10 writes one entry with PC if_pc+4.
REQ-023 Accepted packet with mask 2'b00 and if_excp=0 SHALL write nothing.
REQ-024 If if_excp=1, SHALL write exactly one entry: first valid slot's PC (if_pc if mask 2'b00), inst 32'h0340_0000 (nop), excp=1, ecode=if_ecode; other slot dropped.
REQ-025 Normal entries SHALL carry excp=0, ecode=0.
REQ-026 Head SHALL be presented combinationally from storage; an entry pushed in cycle N is visible on id_* in cycle N+1 at the earliest.
REQ-027 id_valid SHALL equal (count != 0); id_pc, id_inst, id_excp, id_ecode SHALL be 0 when id_valid=0.
REQ-028 Simultaneous push of k entries and pop SHALL give count_next = count + k - 1; order preserved (FIFO).
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; full (count=DEPTH) and empty (count=0) distinguished by count.
REQ-030 Flush SHALL set count, read pointer, write pointer to 0 next cycle; a same-cycle push or pop SHALL be discarded; id_valid=0 in the following cycle.
REQ-031 Flush SHALL take priority over reset-independent activity; rstn low SHALL take priority over flush.

Reset
REQ-032 On rstn=0 at a clock edge: count=0, pointers=0, id_valid=0, id_* outputs=0, if_ready=1 next cycle; storage contents need not reset.
REQ-033 Reset asserted mid-operation SHALL discard all entries identically to REQ-032; no pop or push completes that cycle.

Verification
REQ-034 Push packet pc=0x1C000000, mask 2'b11, inst0=0x02800421, inst1=0x02800842, id_ready=1 -> cycle+1 id_pc=0x1C000000/inst0, cycle+2 id_pc=0x1C000004/inst1, then id_valid=0.
REQ-035 mask 2'b10, pc=0x100 -> single entry id_pc=0x104, count=1.
REQ-036 id_ready=0, push 4 full packets with DEPTH=8 -> count=8, if_ready=0 after count reaches 7; further if_valid ignored; drain yields 8 entries in order.
REQ-037 if_excp=1, ecode=0x08, mask 2'b11, pc=0x200 -> one entry: id_pc=0x200, id_inst=0x03400000, id_excp=1, id_ecode=0x08.
REQ-038 count=5 with push and pop in the same cycle as flush=1 -> next cycle count=0, id_valid=0, if_ready=1.
REQ-039 count=3, pointers wrapped past DEPTH-1, rstn=0 for one cycle -> count=0, id_valid=0; new push after reset appears at head with correct PC.
